txpyhdr_ser: RTL and testbench



---
 rtl/txpy_pkg.sv | 8 +
 rtl/txpy_bytesr.sv | 18 +
 rtl/txpyhdr_ser.sv | 106 ++++++++++
 tb/tb_txpyhdr_ser.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/txpy_pkg.sv
// txpy_pkg: shared types and constants for the transmit payload header serializer.
package txpy_pkg;
    typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} txpy_state_t;
    localparam int HDR_SS_W  = 8;
    localparam int HDR_MS_W  = 16;
    localparam int MAXLEN_SS = 31;
    localparam int MAXLEN_MS = 1021;
endpackage

// File: rtl/txpy_bytesr.sv
// txpy_bytesr: 8-bit payload byte register, LSB-first shift, zero substitute on underrun.
module txpy_bytesr (
    input  logic       clk_6M,
    input  logic       rst,
    input  logic       i_load,
    input  logic       i_shift,
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    output logic       o_bit
);
    logic [7:0] r_dsr;
    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) r_dsr <= 8'h00;
        else if (i_load) r_dsr <= i_valid ? i_byte : 8'h00;
        else if (i_shift) r_dsr <= r_dsr >> 1;
    end
    assign o_bit = r_dsr[0];
endmodule

// File: rtl/txpyhdr_ser.sv
// txpyhdr_ser: ACL payload header generator and LSB-first payload byte serializer.
// Define TXPY_LENCLIP_EN to clip the length to the slot-type maximum.
module txpyhdr_ser #(
    parameter int MAXLEN_MS = txpy_pkg::MAXLEN_MS,
    parameter int MAXLEN_SS = txpy_pkg::MAXLEN_SS
) (
    input  logic       clk_6M,
    input  logic       rst,
    input  logic       py_st_p,
    input  logic       py_datvalid_p,
    input  logic       daten,
    input  logic       BRss,
    input  logic       existpyheader,
    input  logic [1:0] tx_LLID,
    input  logic       tx_FLOW,
    input  logic [9:0] tx_pylenByte,
    input  logic [7:0] txbyte,
    input  logic       txbyte_valid,
    output logic       txbyte_rd,
    output logic       txpybitin,
    output logic       tx_busy,
    output logic       tx_done_p,
    output logic       tx_underrun
);
    import txpy_pkg::*;
    txpy_state_t r_state, w_state_nxt;
    logic [15:0] r_hsr;
    logic [3:0]  r_bcnt;
    logic [9:0]  r_rcnt;
    logic        r_brss, r_underrun;
    logic [9:0]  w_len;
    logic [15:0] w_hdr_word;
    logic        w_adv, w_hlast, w_blast, w_fetch, w_dbit;
`ifdef TXPY_LENCLIP_EN
    logic [9:0] w_cap;
    assign w_cap = BRss ? 10'(MAXLEN_SS) : 10'(MAXLEN_MS);
    assign w_len = (tx_pylenByte > w_cap) ? w_cap : tx_pylenByte;
`else
    assign w_len = tx_pylenByte;
`endif
    assign w_hdr_word = BRss ? {8'h00, w_len[4:0], tx_FLOW, tx_LLID}
                             : {3'b000, w_len, tx_FLOW, tx_LLID};
    assign tx_busy   = (r_state == HDR) || (r_state == DATA);
    assign w_adv     = py_datvalid_p & daten & tx_busy;
    assign w_hlast   = r_bcnt == (r_brss ? 4'(HDR_SS_W - 1) : 4'(HDR_MS_W - 1));
    assign w_blast   = r_bcnt[2:0] == 3'd7;
    assign txbyte_rd = w_fetch;
    assign tx_done_p = r_state == DONE;
    assign tx_underrun = r_underrun;
    assign txpybitin = (r_state == HDR) ? r_hsr[0] : (r_state == DATA) ? w_dbit : 1'b0;
    always_comb begin
        w_state_nxt = r_state;
        w_fetch = 1'b0;
        if (py_st_p) begin
            w_state_nxt = existpyheader ? HDR : (w_len == 10'd0) ? DONE : DATA;
            w_fetch = !existpyheader && (w_len != 10'd0);
        end else begin
            case (r_state)
                HDR: if (w_adv && w_hlast) begin
                    w_state_nxt = (r_rcnt != 10'd0) ? DATA : DONE;
                    w_fetch = r_rcnt != 10'd0;
                end
                DATA: if (w_adv && w_blast) begin
                    w_state_nxt = (r_rcnt != 10'd1) ? DATA : DONE;
                    w_fetch = r_rcnt != 10'd1;
                end
                DONE: w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end
    // rcnt holds the bytes still to send; it drops as each byte's last bit leaves
    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            r_hsr      <= '0;
            r_bcnt     <= '0;
            r_rcnt     <= '0;
            r_brss     <= 1'b0;
            r_underrun <= 1'b0;
        end else if (py_st_p) begin
            r_hsr      <= w_hdr_word;
            r_bcnt     <= '0;
            r_rcnt     <= w_len;
            r_brss     <= BRss;
            r_underrun <= w_fetch & ~txbyte_valid;
        end else begin
            if (w_adv) r_bcnt <= (r_state == HDR && w_hlast) ? 4'd0 : r_bcnt + 4'd1;
            if (w_adv && r_state == HDR) r_hsr <= r_hsr >> 1;
            if (w_adv && r_state == DATA && w_blast) r_rcnt <= r_rcnt - 10'd1;
            if (w_fetch && !txbyte_valid) r_underrun <= 1'b1;
        end
    end
    txpy_bytesr u_bytesr (
        .clk_6M (clk_6M),
        .rst    (rst),
        .i_load (w_fetch),
        .i_shift(w_adv && r_state == DATA && !py_st_p),
        .i_valid(txbyte_valid),
        .i_byte (txbyte),
        .o_bit  (w_dbit)
    );
endmodule

// File: tb/tb_txpyhdr_ser.sv
// tb_txpyhdr_ser: randomized scoreboard bench for txpyhdr_ser (honours TXPY_LENCLIP_EN).
module tb_txpyhdr_ser;
    logic       clk_6M = 0, rst = 1, py_st_p = 0, py_datvalid_p = 0, daten = 0;
    logic       BRss = 0, existpyheader = 0, tx_FLOW = 0, txbyte_valid = 0;
    logic [1:0] tx_LLID = 0;
    logic [9:0] tx_pylenByte = 0;
    logic [7:0] txbyte = 0;
    logic       txbyte_rd, txpybitin, tx_busy, tx_done_p, tx_underrun;
    int n_cmp = 0, n_bad = 0;
    int rd_cnt = 0, adv_cnt = 0, done_cnt = 0;
    bit rd_at_start = 0;
    bit exp_q[$];
    logic [7:0] pkt_bytes[$];

    txpyhdr_ser dut (
        .clk_6M(clk_6M), .rst(rst), .py_st_p(py_st_p), .py_datvalid_p(py_datvalid_p),
        .daten(daten), .BRss(BRss), .existpyheader(existpyheader), .tx_LLID(tx_LLID),
        .tx_FLOW(tx_FLOW), .tx_pylenByte(tx_pylenByte), .txbyte(txbyte),
        .txbyte_valid(txbyte_valid), .txbyte_rd(txbyte_rd), .txpybitin(txpybitin),
        .tx_busy(tx_busy), .tx_done_p(tx_done_p), .tx_underrun(tx_underrun)
    );

    always #5 clk_6M = ~clk_6M;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor: every accepted strobe pops one expected bit
    always @(negedge clk_6M) begin
        if (!rst) begin
            if (txbyte_rd) begin
                rd_cnt++;
                if (py_st_p) rd_at_start = 1;
            end
            if (py_datvalid_p && daten && tx_busy && !py_st_p) begin
                adv_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_adv: got bit %0d expected no more bits", txpybitin);
                end else chk("bit", txpybitin, exp_q.pop_front());
            end
            if (tx_done_p) begin
                done_cnt++;
                chk("bits_left_at_done", exp_q.size(), 0);
            end
        end
    end

    function automatic int eff_len(input bit brss, input int len);
`ifdef TXPY_LENCLIP_EN
        int cap = brss ? 31 : 1021;
        return (len > cap) ? cap : len;
`else
        return len;
`endif
    endfunction

    task automatic build_exp(input bit brss, input bit hdr, input logic [1:0] llid,
                             input bit flow, input int L, input int urun);
        exp_q.delete();
        if (hdr) begin
            int nb = brss ? 8 : 16;
            int fw = brss ? 5 : 10;
            int field = brss ? L % 32 : L % 1024;
            exp_q.push_back(llid[0]);
            exp_q.push_back(llid[1]);
            exp_q.push_back(flow);
            for (int i = 0; i < nb - 3; i++) exp_q.push_back(i < fw ? bit'((field >> i) & 1) : 1'b0);
        end
        for (int b = 0; b < L; b++)
            for (int i = 0; i < 8; i++) exp_q.push_back(b == urun ? 1'b0 : pkt_bytes[b][i]);
    endtask

    task automatic run_pkt(input bit brss, input bit hdr, input logic [1:0] llid, input bit flow,
                           input int len, input int urun, input int abort);
        int L = eff_len(brss, len);
        int nadv = (hdr ? (brss ? 8 : 16) : 0) + 8 * L;
        bit ended = 0;
        bit exp_ur = (urun >= 0) && (urun < L);
        while (pkt_bytes.size() < L) pkt_bytes.push_back(8'($urandom));
        build_exp(brss, hdr, llid, flow, L, urun);
        rd_cnt = 0; adv_cnt = 0; done_cnt = 0; rd_at_start = 0;
        BRss = brss; existpyheader = hdr; tx_LLID = llid; tx_FLOW = flow;
        tx_pylenByte = 10'(len);
        py_st_p = 1; py_datvalid_p = 1'($urandom); daten = 1;
        txbyte = (L > 0) ? pkt_bytes[0] : 8'hEE;
        txbyte_valid = urun != 0;
        for (int cyc = 0; cyc < 20 * nadv + 20; cyc++) begin
            @(posedge clk_6M); #1;
            py_st_p = 0;
            if (cyc == 0) begin
                chk("start_rd", rd_at_start, !hdr && L > 0);
                chk("start_underrun", tx_underrun, !hdr && L > 0 && urun == 0);
                if (hdr) chk("first_hdr_bit", txpybitin, llid[0]);
                if (!hdr && L == 0) chk("zero_len_done", tx_done_p, 1);
            end
            if (done_cnt > 0 || (abort > 0 && adv_cnt >= abort)) begin
                ended = 1;
                break;
            end
            py_datvalid_p = 1'($urandom);
            daten = ($urandom % 4) != 0;
            txbyte = (rd_cnt < L) ? pkt_bytes[rd_cnt] : 8'hEE;
            txbyte_valid = rd_cnt != urun;
        end
        py_datvalid_p = 0;
        if (!ended) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got %0d strobes expected %0d", adv_cnt, nadv);
        end else if (abort > 0) begin
            chk("abort_no_done", done_cnt, 0);
        end else begin
            chk("adv_total", adv_cnt, nadv);
            chk("rd_count", rd_cnt, L);
            chk("done_count", done_cnt, 1);
            chk("underrun", tx_underrun, exp_ur);
            @(posedge clk_6M); #1;
            chk("idle_outputs", {tx_busy, txpybitin, tx_done_p, txbyte_rd}, 0);
            chk("underrun_hold", tx_underrun, exp_ur);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk_6M);
        #1;
        chk("reset_outputs", {txbyte_rd, txpybitin, tx_busy, tx_done_p, tx_underrun}, 0);
        rst = 0;
        @(posedge clk_6M); #1;
        pkt_bytes = '{8'hA5, 8'h3C, 8'hFF};
        run_pkt(1, 1, 2'b10, 1, 3, -1, 0);
        pkt_bytes.delete();
        run_pkt(0, 1, 2'b01, 0, 'h155, -1, 0);
        pkt_bytes.delete();
        run_pkt(1, 1, 2'b00, 0, 4, 1, 0);
        pkt_bytes.delete();
        run_pkt(1, 0, 2'b00, 0, 0, -1, 0);
        pkt_bytes.delete();
        run_pkt(0, 0, 2'b11, 1, 1, -1, 0);
        pkt_bytes.delete();
        run_pkt(0, 1, 2'b11, 1, 5, -1, 20);
        pkt_bytes.delete();
        run_pkt(1, 1, 2'b01, 1, 40, -1, 0);
        pkt_bytes.delete();
        run_pkt(1, 1, 2'b10, 0, 5, 1, 20);
        chk("pre_reset_underrun", tx_underrun, 1);
        #2 rst = 1;
        #1 chk("async_reset", {txbyte_rd, txpybitin, tx_busy, tx_done_p, tx_underrun}, 0);
        @(posedge clk_6M); #1;
        chk("held_reset", {txbyte_rd, txpybitin, tx_busy, tx_done_p, tx_underrun}, 0);
        rst = 0;
        for (int k = 0; k < 8; k++) begin
            int len = $urandom_range(0, 44);
            int ur = ($urandom % 3 == 0) ? int'($urandom_range(0, len)) : -1;
            pkt_bytes.delete();
            run_pkt(1'($urandom), ($urandom % 4) != 0, 2'($urandom), 1'($urandom), len, ur, 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
